// File: rtl/lif_step_scheduler.sv
// Time-multiplexed LIF neuron scheduler: one shared leak/integrate/fire datapath
// visits each virtual neuron once per requested timestep, one neuron per clock.
//
// state | meaning
// IDLE  | waiting for step; config writes accepted
// RUN   | updating neuron idx this cycle
// DONE  | one-cycle wrap-up; publishes spike_vec and pulses done
module lif_step_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8,
    parameter int REFRAC    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         step,
    input  logic                         cfg_we,
    input  logic [$clog2(N_NEURONS):0]   cfg_addr,
    input  logic [WIDTH-1:0]             cfg_data,
    input  logic [$clog2(N_NEURONS)-1:0] mon_sel,
    output logic                         busy,
    output logic                         done,
    output logic                         spike_valid,
    output logic [$clog2(N_NEURONS)-1:0] spike_id,
    output logic [N_NEURONS-1:0]         spike_vec,
    output logic [WIDTH-1:0]             mon_v,
    output logic                         err
);
    localparam int IW = $clog2(N_NEURONS);
    localparam int AW = IW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [IW-1:0]        idx;
    logic [WIDTH-1:0]     v    [N_NEURONS];
    logic [WIDTH-1:0]     cur  [N_NEURONS];
    logic [3:0]           refr [N_NEURONS];
    logic [WIDTH-1:0]     thr;
    logic [2:0]           leak_shift;
    logic [N_NEURONS-1:0] pend;

    logic                 busy_r, done_r, sv_r, err_r;
    logic [IW-1:0]        sid_r;
    logic [N_NEURONS-1:0] svec_r;
    logic [WIDTH-1:0]     mon_r;

    logic [WIDTH-1:0]     v_cur, vl, s_sat;
    logic [WIDTH:0]       sum;
    logic                 in_refr, fire;

    // shift of 0 would subtract v from itself, so leak is bypassed instead
    always_comb begin
        v_cur   = v[idx];
        vl      = (leak_shift == 3'd0) ? v_cur : v_cur - (v_cur >> leak_shift);
        sum     = {1'b0, vl} + {1'b0, cur[idx]};
        s_sat   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        in_refr = (refr[idx] != 4'd0);
        fire    = !in_refr && (s_sat >= thr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            thr        <= {WIDTH{1'b1}};
            leak_shift <= 3'd0;
            pend       <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sv_r       <= 1'b0;
            err_r      <= 1'b0;
            sid_r      <= '0;
            svec_r     <= '0;
            mon_r      <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v[i]    <= '0;
                cur[i]  <= '0;
                refr[i] <= 4'd0;
            end
        end else if (ena) begin
            mon_r  <= v[mon_sel];
            done_r <= 1'b0;
            sv_r   <= 1'b0;
            err_r  <= (state != IDLE) && (step || cfg_we);

            if (cfg_we && state == IDLE) begin
                if (!cfg_addr[AW-1])
                    cur[cfg_addr[IW-1:0]] <= cfg_data;
                else if (cfg_addr[IW-1:0] == IW'(0))
                    thr <= cfg_data;
                else if (cfg_addr[IW-1:0] == IW'(1))
                    leak_shift <= cfg_data[2:0];
            end

            case (state)
                IDLE: begin
                    if (step) begin
                        state  <= RUN;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        pend   <= '0;
                    end
                end
                RUN: begin
                    if (in_refr) begin
                        v[idx]    <= '0;
                        refr[idx] <= refr[idx] - 4'd1;
                    end else if (fire) begin
                        v[idx]    <= '0;
                        refr[idx] <= 4'(REFRAC);
                    end else begin
                        v[idx]    <= s_sat;
                    end
                    pend[idx] <= fire;
                    sv_r      <= fire;
                    sid_r     <= idx;
                    if (idx == IW'(N_NEURONS - 1)) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    svec_r <= pend;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // pulse outputs keep their flop value through a freeze but read 0 while ena is low
    assign busy        = busy_r;
    assign done        = done_r & ena;
    assign spike_valid = sv_r & ena;
    assign err         = err_r & ena;
    assign spike_id    = sid_r;
    assign spike_vec   = svec_r;
    assign mon_v       = mon_r;
endmodule

// File: tb/tb_lif_step_scheduler.sv
// Directed bench for lif_step_scheduler (N=4, WIDTH=8, REFRAC=2); expected
// values are hand-computed from the LIF update rule and timestep timing.
module tb_lif_step_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       step = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic [1:0] mon_sel = '0;
    logic       busy, done, spike_valid, err;
    logic [1:0] spike_id;
    logic [3:0] spike_vec;
    logic [7:0] mon_v;

    int total = 0;
    int bad = 0;

    lif_step_scheduler #(.N_NEURONS(4), .WIDTH(8), .REFRAC(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .step(step), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .mon_sel(mon_sel),
        .busy(busy), .done(done), .spike_valid(spike_valid), .spike_id(spike_id),
        .spike_vec(spike_vec), .mon_v(mon_v), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step = 0; cfg_we = 0; ena = 1;
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 0;
    endtask

    // Issue one step (any cfg_we already set rides along) and follow it to idle.
    task automatic run_step(output int done_at, output int busy_len, output logic [3:0] mask,
                            output int sp_off, output int sp_id);
        done_at = -1; busy_len = -1; mask = '0; sp_off = -1; sp_id = -1;
        step = 1;
        tick();
        step = 0; cfg_we = 0;
        for (int off = 1; off < 40; off++) begin
            if (done === 1'b1 && done_at < 0) done_at = off;
            if (spike_valid === 1'b1) begin
                mask[spike_id] = 1'b1;
                if (sp_off < 0) begin sp_off = off; sp_id = int'(spike_id); end
            end
            if (busy !== 1'b1) begin busy_len = off - 1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        int da, bl, so, si;
        logic [3:0] m;
        do_reset();
        total++; if ({busy, done, spike_valid, err} !== 4'b0) begin bad++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, spike_valid, err}); end
        total++; if (spike_vec !== 4'h0 || spike_id !== 2'd0) begin bad++;
            $display("FAIL reset_spike got vec=%h id=%0d want 0/0", spike_vec, spike_id); end
        total++; if (mon_v !== 8'd0) begin bad++;
            $display("FAIL reset_mon got %0d want 0", mon_v); end
        run_step(da, bl, m, so, si);
        total++; if (bl != 5) begin bad++; $display("FAIL reset_busy_len got %0d want 5", bl); end
        total++; if (da != 5) begin bad++; $display("FAIL reset_done_at got %0d want 5", da); end
        total++; if (spike_vec !== 4'h0 || m !== 4'h0) begin bad++;
            $display("FAIL reset_step_spikes got vec=%h seen=%h want 0/0", spike_vec, m); end
    endtask

    task automatic test_integrate_fire();
        int da, bl, so, si;
        logic [3:0] m;
        logic [7:0] exp_v [5] = '{8'd60, 8'd0, 8'd0, 8'd0, 8'd60};
        logic [3:0] exp_s [5] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
        do_reset();
        mon_sel = 2'd0;
        cfg_write(3'b100, 8'd100);
        cfg_write(3'b000, 8'd60);
        for (int s = 0; s < 5; s++) begin
            run_step(da, bl, m, so, si);
            total++; if (mon_v !== exp_v[s]) begin bad++;
                $display("FAIL integ_mon step%0d got %0d want %0d", s + 1, mon_v, exp_v[s]); end
            total++; if (spike_vec !== exp_s[s] || m !== exp_s[s]) begin bad++;
                $display("FAIL integ_spikes step%0d got vec=%h seen=%h want %h", s + 1, spike_vec, m, exp_s[s]); end
            if (s == 1) begin
                total++; if (so != 2 || si != 0) begin bad++;
                    $display("FAIL integ_spike_time got off=%0d id=%0d want 2/0", so, si); end
            end
        end
    endtask

    task automatic test_leak();
        int da, bl, so, si;
        logic [3:0] m;
        logic [7:0] exp_v [4] = '{8'd80, 8'd140, 8'd185, 8'd0};
        logic [3:0] exp_s [4] = '{4'h0, 4'h0, 4'h0, 4'h2};
        do_reset();
        mon_sel = 2'd1;
        cfg_write(3'b100, 8'd200);
        cfg_write(3'b001, 8'd80);
        cfg_write(3'b101, 8'd2);
        for (int s = 0; s < 4; s++) begin
            run_step(da, bl, m, so, si);
            total++; if (mon_v !== exp_v[s]) begin bad++;
                $display("FAIL leak_mon step%0d got %0d want %0d", s + 1, mon_v, exp_v[s]); end
            total++; if (spike_vec !== exp_s[s]) begin bad++;
                $display("FAIL leak_vec step%0d got %h want %h", s + 1, spike_vec, exp_s[s]); end
        end
    endtask

    task automatic test_saturation();
        int da, bl, so, si;
        logic [3:0] m;
        do_reset();
        mon_sel = 2'd2;
        cfg_write(3'b010, 8'd200);
        run_step(da, bl, m, so, si);
        total++; if (mon_v !== 8'd200 || m !== 4'h0) begin bad++;
            $display("FAIL sat_step1 got v=%0d seen=%h want 200/0", mon_v, m); end
        run_step(da, bl, m, so, si);
        total++; if (so != 4 || si != 2 || spike_vec !== 4'h4 || mon_v !== 8'd0) begin bad++;
            $display("FAIL sat_step2 got off=%0d id=%0d vec=%h v=%0d want 4/2/4/0", so, si, spike_vec, mon_v); end
    endtask

    task automatic test_collisions();
        int da, bl, so, si, dat, eoff;
        logic [3:0] m;
        // step while busy
        do_reset();
        step = 1; tick(); step = 0;   // t+1
        tick();                       // t+2
        step = 1; tick(); step = 0;   // t+3
        total++; if (err !== 1'b1) begin bad++; $display("FAIL coll_step_err got %b want 1", err); end
        dat = -1;
        for (int off = 3; off < 40; off++) begin
            if (done === 1'b1 && dat < 0) dat = off;
            if (busy !== 1'b1) break;
            tick();
        end
        total++; if (dat != 5) begin bad++; $display("FAIL coll_step_done got %0d want 5", dat); end
        // cfg write while busy
        do_reset();
        mon_sel = 2'd0;
        step = 1; tick(); step = 0;   // t+1
        cfg_we = 1; cfg_addr = 3'b000; cfg_data = 8'd77;
        tick(); cfg_we = 0;           // t+2
        total++; if (err !== 1'b1) begin bad++; $display("FAIL coll_cfg_err got %b want 1", err); end
        for (int k = 0; k < 10 && busy === 1'b1; k++) tick();
        run_step(da, bl, m, so, si);
        total++; if (mon_v !== 8'd0) begin bad++; $display("FAIL coll_cfg_dropped got v=%0d want 0", mon_v); end
        // ena low three cycles mid-run
        do_reset();
        step = 1; tick(); step = 0;   // t+1
        tick();                       // t+2
        ena = 0; step = 1;
        tick(); tick(); tick();       // t+5
        ena = 1; step = 0;
        total++; if (busy !== 1'b1 || err !== 1'b0) begin bad++;
            $display("FAIL coll_ena_hold got busy=%b err=%b want 1/0", busy, err); end
        dat = -1; eoff = 0;
        for (int off = 5; off < 40; off++) begin
            if (done === 1'b1 && dat < 0) dat = off;
            if (err === 1'b1) eoff = off;
            if (busy !== 1'b1) break;
            tick();
        end
        total++; if (dat != 8) begin bad++; $display("FAIL coll_ena_done got %0d want 8", dat); end
        total++; if (eoff != 0) begin bad++; $display("FAIL coll_ena_err got err at %0d want none", eoff); end
    endtask

    task automatic test_reset_mid_run();
        int da, bl, so, si;
        logic [3:0] m;
        do_reset();
        cfg_write(3'b000, 8'd255);
        step = 1; tick(); step = 0;
        tick();
        rst_n = 0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
            $display("FAIL rst_mid_async got busy=%b done=%b want 0/0", busy, done); end
        tick();
        rst_n = 1;
        for (int n = 0; n < 4; n++) begin
            mon_sel = 2'(n);
            tick();
            total++; if (mon_v !== 8'd0) begin bad++;
                $display("FAIL rst_mid_v%0d got %0d want 0", n, mon_v); end
        end
        cfg_we = 1; cfg_addr = 3'b011; cfg_data = 8'd255;
        run_step(da, bl, m, so, si);
        total++; if (so != 5 || si != 3 || spike_vec !== 4'h8) begin bad++;
            $display("FAIL rst_mid_sim got off=%0d id=%0d vec=%h want 5/3/8", so, si, spike_vec); end
    endtask

    initial begin
        test_reset();
        test_integrate_fire();
        test_leak();
        test_saturation();
        test_collisions();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lif_step_scheduler.md
Name: lif_step_scheduler

Overview:
- Time-multiplexed scheduler for the leaky integrate-and-fire (LIF) neuron tile.
- Sequences N virtual neurons through one shared LIF update datapath, one neuron per clock, once per timestep.
- Owns per-neuron membrane, input-current and refractory state, plus global threshold and leak configuration.
- Sits between the tt_um top-level pin decode (config writes, step strobe) and the spike/monitor outputs.

Parameters:
- N_NEURONS, 4, number of virtual neurons; power of two, 2..16.
- WIDTH, 8, membrane, current and threshold width in bits.
- REFRAC, 2, refractory timesteps after a spike; 0..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; low freezes all state.
- step  in  1  single-cycle strobe; request one timestep.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  $clog2(N_NEURONS)+1  MSB=0: current register [idx]; MSB=1, idx=0: threshold; MSB=1, idx=1: leak_shift (low 3 bits); other addresses ignored.
- cfg_data  in  WIDTH  write data.
- mon_sel  in  $clog2(N_NEURONS)  membrane monitor select.
- busy  out  1  timestep in progress.
- done  out  1  one-cycle pulse at end of timestep.
- spike_valid  out  1  registered per-neuron spike event.
- spike_id  out  $clog2(N_NEURONS)  neuron index for spike_valid.
- spike_vec  out  N_NEURONS  spikes of the last completed timestep.
- mon_v  out  WIDTH  registered membrane value of neuron mon_sel.
- err  out  1  one-cycle pulse on rejected step or cfg write.

Behaviour:
- Reset (async): all outputs 0; all membrane, current and refractory state 0; threshold all-ones; leak_shift 0; FSM in IDLE.
- FSM states:
  - IDLE -> RUN on step & ena; idx cleared.
  - RUN processes idx per cycle; leaves for DONE after idx = N_NEURONS-1.
  - DONE lasts one cycle, then returns to IDLE.
- Timing, step sampled in cycle t:
  - busy is 1 during cycles t+1 .. t+N+1.
  - Neuron k is processed in cycle t+1+k; its state is written at the end of that cycle.
  - Its spike_valid/spike_id appear in cycle t+2+k.
  - done = 1 in cycle t+N+1.
  - spike_vec is updated with that step's spikes and visible from t+N+2.
  - A new step is accepted in cycle t+N+2 at the earliest.
- Update for neuron k (v, I, r = its membrane, current and refractory count):
  - If r > 0: v' = 0, r' = r-1, no spike.
  - Else: vl = v when leak_shift = 0, otherwise vl = v - (v >> leak_shift).
  - Else: s = vl + I, saturating at 2^WIDTH-1.
  - Else: if s >= threshold, spike; v' = 0; r' = REFRAC. Otherwise v' = s.
- Threshold 0 is legal: every non-refractory neuron spikes each step.
- step while busy: ignored; err pulses the next cycle.
- cfg_we while busy: write dropped; err pulses the next cycle.
- Simultaneous step and cfg_we in IDLE: the write is applied and the step is accepted; the new value is used by that step.
- ena low: FSM, idx and all state hold; step and cfg_we are ignored with no err; outputs hold their last values. done, spike_valid and err are pulses and are forced 0 while ena is low.
- mon_v is registered: value of v[mon_sel] at the previous clock edge.
- Reset asserted mid-RUN: immediate return to reset state; partial timestep discarded.
- With N=1 the RUN state lasts one cycle.

Test Plan:
- Reset, then idle: all outputs 0, threshold 255, mon_v 0; step → busy for 5 cycles (N=4), done at t+5, spike_vec = 0.
- Integrate, fire, refractory: thr=100, I0=60, leak=0; steps 1..5.
  - mon_v(0) after each step: 60, 0 (spike_valid with id 0 at t+2 of step 2, spike_vec=0001), 0, 0, 60.
  - No spikes on steps 3 and 4.
- Leak: thr=200, I1=80, leak_shift=2; mon_v(1) after steps 1..3 = 80, 140, 185; step 4 spikes neuron 1 (sum 219), v=0, spike_vec=0010.
- Saturation: thr=255, I2=200; step 1 v=200; step 2 sum saturates to 255 ≥ 255 → spike id 2.
- Collisions:
  - step at t+2 of a running step → err at t+3; timestep length unchanged.
  - cfg_we during busy → err; value unchanged afterwards.
  - ena low for 3 cycles mid-RUN → done delayed by exactly 3 cycles.
- Reset mid-RUN, then simultaneous step and write of I3=255 with thr=255: after reset all state is 0; the step sees the new I3 and spikes neuron 3 on its first update.
